// File: rtl/usb_txn_scheduler.sv
// usb_txn_scheduler: shares one USB host transaction engine between N_REQ
// requesters. A round-robin arbiter picks a requester, the FSM launches the
// attempt, waits for the engine (with a timeout), retries failed attempts after
// a fixed backoff and finally reports success or failure to the requester.
module usb_txn_scheduler #(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255,
  parameter int BACKOFF   = 4,
  localparam int RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_kind,
  input  logic [7*N_REQ-1:0]   req_addr,
  output logic [N_REQ-1:0]     req_grant,
  output logic [N_REQ-1:0]     req_done,
  output logic                 req_ok,
  output logic                 txn_start,
  output logic                 txn_kind,
  output logic [6:0]           txn_addr,
  input  logic                 txn_done,
  input  logic                 txn_success,
  output logic                 busy,
  output logic [RETRY_W-1:0]   retry_cnt
);

  localparam int SEL_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int BO_W  = (BACKOFF < 2) ? 1 : $clog2(BACKOFF);

  // The attempt fails on the TIMEOUT-th WAIT cycle without txn_done, i.e. when
  // the counter (cleared in ISSUE) sits at TIMEOUT-1 in that cycle.
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [BO_W-1:0]    BO_LAST     = BO_W'(BACKOFF - 1);
  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
  localparam logic [SEL_W-1:0]   LAST_RST    = SEL_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic                kind_q, kind_d;
  logic [6:0]          addr_q, addr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                ok_q, ok_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [BO_W-1:0]     bo_q, bo_d;

  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;
  logic                pick_kind;
  logic [6:0]          pick_addr;
  logic                attempt_failed;
  int                  cand;

  // Round-robin pick: scan from the requester after the last one served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_kind  = 1'b0;
    pick_addr  = '0;
    cand       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(last_q) + 1 + k) % N_REQ;
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = SEL_W'(cand);
        pick_kind  = req_kind[cand];
        pick_addr  = req_addr[7*cand +: 7];
      end
    end
  end

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    last_d         = last_q;
    kind_d         = kind_q;
    addr_d         = addr_q;
    grant_d        = '0;
    done_d         = '0;
    ok_d           = 1'b0;
    start_d        = 1'b0;
    retry_d        = retry_q;
    tmo_d          = tmo_q;
    bo_d           = bo_q;
    attempt_failed = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d           = S_ISSUE;
          sel_d             = pick_idx;
          kind_d            = pick_kind;
          addr_d            = pick_addr;
          grant_d[pick_idx] = 1'b1;
          start_d           = 1'b1;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end

      S_WAIT: begin
        if (txn_done) begin
          if (txn_success) begin
            state_d       = S_REPORT;
            ok_d          = 1'b1;
            done_d[sel_q] = 1'b1;
          end else begin
            attempt_failed = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          attempt_failed = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end

        if (attempt_failed) begin
          if (retry_q < MAX_RETRY_C) begin
            retry_d = retry_q + 1'b1;
            bo_d    = '0;
            if (BACKOFF == 0) begin
              state_d = S_ISSUE;
              start_d = 1'b1;
            end else begin
              state_d = S_BACKOFF;
            end
          end else begin
            state_d       = S_REPORT;
            ok_d          = 1'b0;
            done_d[sel_q] = 1'b1;
          end
        end
      end

      S_BACKOFF: begin
        if (bo_q == BO_LAST) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
        last_d  = sel_q;
        retry_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops everything back to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      kind_q  <= 1'b0;
      addr_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      ok_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      retry_q <= '0;
      tmo_q   <= '0;
      bo_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      bo_q    <= bo_d;
    end
  end

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign req_ok    = ok_q;
  assign txn_start = start_q;
  assign txn_kind  = kind_q;
  assign txn_addr  = addr_q;
  assign busy      = busy_q;
  assign retry_cnt = retry_q;

endmodule
